// File: rtl/serial_comparator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_comparator : digit-serial magnitude compare, MSB digit first, with
//                     early termination on the first differing digit.
// Revision: 1.0
// ---------------------------------------------------------------------------
module serial_comparator #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] w0,
   input  logic [WIDTH-1:0] w1,
   output logic             busy,
   output logic             done,
   output logic             less,
   output logic             equal,
   output logic             greater
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   if ((WIDTH % DIGIT) != 0) begin : g_width_check
      $error("serial_comparator: WIDTH must be a multiple of DIGIT");
   end

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             less_q, less_d;
   logic             equal_q, equal_d;
   logic             greater_q, greater_d;
   logic [DIGIT-1:0] digit_a, digit_b;
   logic [WIDTH-1:0] sign_flip;

   // Flipping the MSBs maps two's-complement order onto unsigned order.
   assign sign_flip = {signed_mode, {(WIDTH-1){1'b0}}};
   assign digit_a   = a_q[WIDTH-1 -: DIGIT];
   assign digit_b   = b_q[WIDTH-1 -: DIGIT];

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      cnt_d     = cnt_q;
      less_d    = less_q;
      equal_d   = equal_q;
      greater_d = greater_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = w0 ^ sign_flip;
               b_d     = w1 ^ sign_flip;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (digit_a != digit_b) begin
               greater_d = (digit_a > digit_b);
               less_d    = (digit_a < digit_b);
               equal_d   = 1'b0;
               state_d   = DONE;
            end else if (cnt_q == LAST_DIGIT) begin
               greater_d = 1'b0;
               less_d    = 1'b0;
               equal_d   = 1'b1;
               state_d   = DONE;
            end else begin
               a_d   = a_q << DIGIT;
               b_d   = b_q << DIGIT;
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         cnt_q     <= '0;
         less_q    <= 1'b0;
         equal_q   <= 1'b0;
         greater_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         cnt_q     <= cnt_d;
         less_q    <= less_d;
         equal_q   <= equal_d;
         greater_q <= greater_d;
      end
   end

   assign busy    = (state_q == RUN);
   assign done    = (state_q == DONE);
   assign less    = less_q;
   assign equal   = equal_q;
   assign greater = greater_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_comparator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_serial_comparator : directed-vector bench for serial_comparator (16/4).
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_serial_comparator;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        signed_mode = 1'b0;
   logic [15:0] w0 = '0;
   logic [15:0] w1 = '0;
   logic        busy, done, less, equal, greater;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [2:0] F_NONE = 3'b000;
   localparam logic [2:0] F_LT   = 3'b100;
   localparam logic [2:0] F_EQ   = 3'b010;
   localparam logic [2:0] F_GT   = 3'b001;

   serial_comparator #(.WIDTH(16), .DIGIT(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .signed_mode (signed_mode),
      .w0          (w0),
      .w1          (w1),
      .busy        (busy),
      .done        (done),
      .less        (less),
      .equal       (equal),
      .greater     (greater)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issues one compare from an IDLE cycle; returns at the negedge where done is seen.
   task automatic do_cmp(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic sm, input int exp_lat, input logic [2:0] exp_flags,
                         input logic [2:0] prev_flags, input bit disturb);
      int  lat;
      int  busy_cnt;
      bit  got;
      lat = 0; busy_cnt = 0; got = 0;
      @(negedge clk);
      check_val({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
      w0 = a; w1 = b; signed_mode = sm; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      while (!got && lat < 20) begin
         @(negedge clk);
         if (done) begin
            got = 1;
         end else begin
            if (busy) busy_cnt++;
            check_val({tag, "_hold"}, {29'd0, less, equal, greater}, {29'd0, prev_flags});
            if (disturb && lat == 1) begin
               w0 = 16'hFFFF; signed_mode = ~sm; start = 1'b1;
            end
            if (disturb && lat == 2) start = 1'b0;
            @(posedge clk);
            lat++;
         end
      end
      start = 1'b0;
      check_val({tag, "_done"}, {31'd0, got}, 32'd1);
      check_val({tag, "_lat"}, lat, exp_lat);
      check_val({tag, "_busy"}, busy_cnt, exp_lat);
      check_val({tag, "_flags"}, {29'd0, less, equal, greater}, {29'd0, exp_flags});
   endtask

   initial begin
      // reset held two cycles
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_outs", {27'd0, busy, done, less, equal, greater}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check_val("post_rst_flags", {29'd0, less, equal, greater}, 32'd0);

      do_cmp("eq_1234",  16'h1234, 16'h1234, 1'b0, 4, F_EQ, F_NONE, 0);
      do_cmp("u_8000",   16'h8000, 16'h7FFF, 1'b0, 1, F_GT, F_EQ,   0);
      do_cmp("s_8000",   16'h8000, 16'h7FFF, 1'b1, 1, F_LT, F_GT,   0);
      do_cmp("u_0f00",   16'h0F00, 16'h0E00, 1'b0, 2, F_GT, F_LT,   0);
      do_cmp("ignore",   16'h0001, 16'h0002, 1'b0, 4, F_LT, F_GT,   1);

      // start pulsed in RUN must not have queued a second compare
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_val("no_second", {30'd0, busy, done}, 32'd0);
      end

      // reset in the middle of a compare
      @(negedge clk);
      w0 = 16'h1234; w1 = 16'h1234; signed_mode = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check_val("abort_run", {31'd0, busy}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_val("abort_quiet", {27'd0, busy, done, less, equal, greater}, 32'd0);
      end

      // back-to-back: second start lands in the single IDLE cycle after DONE
      do_cmp("b2b_a", 16'h0005, 16'h0003, 1'b0, 4, F_GT, F_NONE, 0);
      do_cmp("b2b_b", 16'h1000, 16'h2000, 1'b0, 1, F_LT, F_GT,   0);
      @(negedge clk);
      check_val("b2b_end", {27'd0, busy, done, less, equal, greater}, {27'd0, 2'b00, F_LT});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/serial_comparator.md
SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 16, operand width in bits.
REQ-002 Parameter DIGIT SHALL be: DIGIT, default 4, bits compared per cycle; WIDTH not a multiple of DIGIT SHALL fail elaboration.
REQ-003 Port clk SHALL be: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port rst SHALL be: rst  input  1  reset, synchronous, active-high.
REQ-005 Port start SHALL be: start  input  1  request to capture operands and begin a compare.
REQ-006 Port signed_mode SHALL be: signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
REQ-007 Port w0 SHALL be: w0  input  WIDTH  first operand.
REQ-008 Port w1 SHALL be: w1  input  WIDTH  second operand.
REQ-009 Port busy SHALL be: busy  output  1  high while compare in progress.
REQ-010 Port done SHALL be: done  output  1  one-cycle pulse, result valid.
REQ-011 Ports less, equal, greater SHALL be: less/equal/greater  output  1 each  registered result, w0 relative to w1.

Function
REQ-012 The FSM SHALL have states IDLE, RUN, DONE; busy = (state==RUN); done = (state==DONE).
REQ-013 In IDLE with start=1, the block SHALL capture w0, w1, signed_mode and enter RUN with digit index 0 at that edge.
REQ-014 Start SHALL be ignored in RUN and DONE; w0/w1/signed_mode changes after capture SHALL not affect the result.
REQ-015 Digits SHALL be processed most-significant first, index d = 0..N-1, N = WIDTH/DIGIT, one digit per RUN cycle.
REQ-016 Signed mode SHALL be implemented as the captured operands' MSBs inverted, then unsigned compare.
REQ-017 On a RUN edge where digit d differs, the block SHALL register greater or less (unsigned digit magnitude) and enter DONE (early termination).
REQ-018 On a RUN edge where digit N-1 is equal and all earlier digits were equal, the block SHALL register equal=1 and enter DONE.
REQ-019 Latency SHALL be: done high d+1 cycles after the start-capture edge for first differing digit d; N cycles when operands are equal.
REQ-020 DONE SHALL last exactly one cycle, then return to IDLE; start in that IDLE cycle SHALL be accepted (back-to-back compares, one idle cycle minimum).
REQ-021 Result flags SHALL change only on the edge entering DONE, be one-hot thereafter, and hold until the next result.
REQ-022 A new capture SHALL not clear the previous result until the next DONE.

Reset
REQ-023 While rst=1 at a rising edge, the state SHALL go to IDLE and busy, done, less, equal, greater SHALL go to 0.
REQ-024 Reset during RUN or DONE SHALL abort the compare with no done pulse; rst has priority over start.
REQ-025 After reset and before the first done, all three flags SHALL read 0.

Verification (WIDTH=16, DIGIT=4)
REQ-026 The bench SHALL cover these cases:
- rst held 2 cycles -> busy=done=less=equal=greater=0.
- unsigned w0=0x1234, w1=0x1234 -> done 4 cycles after start edge; equal=1, less=greater=0.
- w0=0x8000, w1=0x7FFF, signed_mode=0 -> done 1 cycle after start, greater=1; same with signed_mode=1 -> less=1.
- unsigned w0=0x0F00, w1=0x0E00 -> done 2 cycles after start, greater=1; busy high exactly 2 cycles.
- capture 0x0001 vs 0x0002, then drive w0=0xFFFF and pulse start during RUN -> single done at cycle 4, less=1; no second compare.
- start 0x1234 vs 0x1234, assert rst at cycle 2 -> no done, flags 0, IDLE.
- done then start in the next IDLE cycle -> second compare accepted; flags hold the first result until the second done.
